// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive control path.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYNC_WAIT = 3'd1,
        DATA_WAIT = 3'd2,
        STORE     = 3'd3,
        ERR_WAIT  = 3'd4,
        EOP_END   = 3'd5
    } rx_state_t;

    localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

endpackage

// File: rtl/usb_pid_check.sv
// Combinational PID integrity check: the low nibble must be the complement of the high nibble.
module usb_pid_check (
    input  logic [7:0] pid_i,
    output logic       valid_o
);

    assign valid_o = (pid_i[3:0] == ~pid_i[7:4]);

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB RX receive control FSM: SYNC validation, FIFO writes, byte counting and error flagging.
// Optional PID complement check on the first stored byte when USB_RX_PID_CHECK_EN is defined.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = USB_SYNC_BYTE,
    parameter int         MAX_BYTES = 64,
    parameter int         CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_enable,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    input  logic             fifo_full,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic             pkt_done,
    output logic [CNT_W-1:0] byte_count
);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             pkt_q, pkt_d;
    logic             wen_d;
    logic             eop_s;
    logic             pid_ok;
    logic             reject;

`ifdef USB_RX_PID_CHECK_EN
    usb_pid_check u_pid_check (
        .pid_i   (rcv_data),
        .valid_o (pid_ok)
    );
`else
    assign pid_ok = 1'b1;
`endif

    assign eop_s  = shift_enable && eop;
    // The PID check only matters for the first byte after SYNC.
    assign reject = fifo_full
                 || (cnt_q == CNT_W'(MAX_BYTES))
                 || ((cnt_q == '0) && !pid_ok);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pkt_d   = 1'b0;
        wen_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_edge) begin
                    state_d = SYNC_WAIT;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            SYNC_WAIT: begin
                // EOP takes priority over a byte arriving in the same cycle.
                if (eop_s) begin
                    err_d   = 1'b1;
                    state_d = EOP_END;
                end else if (byte_received) begin
                    if (rcv_data == SYNC_BYTE) begin
                        state_d = DATA_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR_WAIT;
                    end
                end
            end
            DATA_WAIT: begin
                if (eop_s) begin
                    state_d = EOP_END;
                    if (cnt_q == '0) begin
                        err_d = 1'b1;
                    end else if (!err_q) begin
                        pkt_d = 1'b1;
                    end
                end else if (byte_received) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                if (reject) begin
                    err_d   = 1'b1;
                    state_d = ERR_WAIT;
                end else begin
                    wen_d   = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = DATA_WAIT;
                end
            end
            ERR_WAIT: begin
                if (eop_s) begin
                    state_d = EOP_END;
                end
            end
            EOP_END: begin
                if (d_edge) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            pkt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
        end
    end

    // Strobes are suppressed while reset is asserted so an aborted packet never writes or completes.
    assign rcving     = (state_q != IDLE);
    assign w_enable   = wen_d && !rst;
    assign pkt_done   = pkt_q && !rst;
    assign r_error    = err_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Scoreboard bench for usb_rx_ctrl (MAX_BYTES=4 so the overflow path is reachable with short packets).
module tb_usb_rx_ctrl;

    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             d_edge;
    logic             eop;
    logic             shift_enable;
    logic             byte_received;
    logic [7:0]       rcv_data;
    logic             fifo_full;
    logic             rcving;
    logic             w_enable;
    logic             r_error;
    logic             pkt_done;
    logic [CNT_W-1:0] byte_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] wq[$];
    int         pq[$];

    usb_rx_ctrl #(
        .SYNC_BYTE (8'h80),
        .MAX_BYTES (4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .fifo_full     (fifo_full),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error),
        .pkt_done      (pkt_done),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT write / completion against the scoreboard queues.
    always @(negedge clk) begin
        if (w_enable && pkt_done) begin
            checks++;
            failures++;
            $display("FAIL wen_pkt_overlap actual=1 required=0");
        end
        if (w_enable) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h required=none", rcv_data);
            end else begin
                check("write_data", {24'd0, rcv_data}, {24'd0, wq.pop_front()});
            end
        end
        if (pkt_done) begin
            if (pq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pkt_done actual=1 required=0");
            end else begin
                check("pkt_done", 32'd1, pq.pop_front());
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_edge();
        eop    = 1'b0;
        d_edge = 1'b1;
        step(1);
        d_edge = 1'b0;
        step(2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rcv_data      = b;
        byte_received = 1'b1;
        step(1);
        byte_received = 1'b0;
        step(3);
    endtask

    task automatic send_eop();
        eop          = 1'b1;
        shift_enable = 1'b1;
        step(1);
        shift_enable = 1'b0;
        step(2);
    endtask

    task automatic queues_empty(input string name);
        check({name, "_writes_left"}, wq.size(), 0);
        check({name, "_pkts_left"}, pq.size(), 0);
    endtask

    initial begin
        rst = 1'b1; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
        byte_received = 1'b0; rcv_data = 8'h00; fifo_full = 1'b0;
        step(2);
        check("rst_rcving", rcving, 0);
        check("rst_wen", w_enable, 0);
        check("rst_err", r_error, 0);
        check("rst_pkt", pkt_done, 0);
        check("rst_cnt", byte_count, 0);
        rst = 1'b0;
        step(2);

        // Good packet
        pulse_edge();
        check("good_rcving", rcving, 1);
        send_byte(8'h80);
        wq.push_back(8'hC3); send_byte(8'hC3);
        wq.push_back(8'h11); send_byte(8'h11);
        wq.push_back(8'h22); send_byte(8'h22);
        check("good_cnt", byte_count, 3);
        pq.push_back(1);
        send_eop();
        check("good_err", r_error, 0);
        check("good_eop_rcving", rcving, 1);
        pulse_edge();
        check("good_idle", rcving, 0);
        queues_empty("good");

        // Bad SYNC
        pulse_edge();
        send_byte(8'h81);
        check("badsync_err", r_error, 1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_eop();
        pulse_edge();
        check("badsync_err_hold", r_error, 1);
        check("badsync_cnt", byte_count, 0);
        queues_empty("badsync");

        // Next packet start clears the error; FIFO full on the second data byte
        pulse_edge();
        check("clear_err", r_error, 0);
        check("clear_cnt", byte_count, 0);
        send_byte(8'h80);
        wq.push_back(8'hC3); send_byte(8'hC3);
        fifo_full = 1'b1;
        send_byte(8'h11);
        fifo_full = 1'b0;
        check("full_err", r_error, 1);
        send_byte(8'h22);
        check("full_cnt", byte_count, 1);
        send_eop();
        pulse_edge();
        queues_empty("full");

        // Overflow: MAX_BYTES=4, five data bytes
        pulse_edge();
        send_byte(8'h80);
        wq.push_back(8'hE1); send_byte(8'hE1);
        wq.push_back(8'hA2); send_byte(8'hA2);
        wq.push_back(8'hA3); send_byte(8'hA3);
        wq.push_back(8'hA4); send_byte(8'hA4);
        check("ovf_cnt4", byte_count, 4);
        check("ovf_err_before", r_error, 0);
        send_byte(8'hA5);
        check("ovf_err", r_error, 1);
        check("ovf_cnt_hold", byte_count, 4);
        send_eop();
        pulse_edge();
        queues_empty("ovf");

        // Empty packet: SYNC then EOP
        pulse_edge();
        send_byte(8'h80);
        send_eop();
        check("empty_err", r_error, 1);
        pulse_edge();
        queues_empty("empty");

        // Byte and EOP in the same cycle: EOP wins, byte dropped
        pulse_edge();
        send_byte(8'h80);
        wq.push_back(8'hC3); send_byte(8'hC3);
        pq.push_back(1);
        rcv_data = 8'h55; byte_received = 1'b1; shift_enable = 1'b1; eop = 1'b1;
        step(1);
        byte_received = 1'b0; shift_enable = 1'b0;
        step(2);
        check("simul_cnt", byte_count, 1);
        check("simul_err", r_error, 0);
        check("simul_rcving", rcving, 1);
        send_byte(8'h66);
        check("simul_hold_cnt", byte_count, 1);
        pulse_edge();
        check("simul_idle", rcving, 0);
        queues_empty("simul");

        // Reset during DATA_WAIT after two stored bytes
        pulse_edge();
        send_byte(8'h80);
        wq.push_back(8'hC3); send_byte(8'hC3);
        wq.push_back(8'h11); send_byte(8'h11);
        check("rstmid_cnt", byte_count, 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rstmid_rcving", rcving, 0);
        check("rstmid_wen", w_enable, 0);
        check("rstmid_err", r_error, 0);
        check("rstmid_pkt", pkt_done, 0);
        check("rstmid_cnt0", byte_count, 0);
        step(2);
        queues_empty("rstmid");

        // PID byte 8'hC4: rejected only with the PID check built in
        pulse_edge();
        send_byte(8'h80);
`ifdef USB_RX_PID_CHECK_EN
        send_byte(8'hC4);
        check("pid_err", r_error, 1);
        check("pid_cnt", byte_count, 0);
        send_eop();
`else
        wq.push_back(8'hC4); send_byte(8'hC4);
        check("pid_err", r_error, 0);
        check("pid_cnt", byte_count, 1);
        pq.push_back(1);
        send_eop();
`endif
        pulse_edge();
        queues_empty("pid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Receive control FSM for the USB RX path. It consumes the bit-timer's `shift_enable` and `byte_received` strobes, plus the line-edge and EOP detectors. It drives `rcving` back to the timer, validates the SYNC byte, writes packet bytes into the RX FIFO, and flags protocol errors. It sits between the RX front end (edge detect, EOP detect, timer, shift register) and the RX FIFO.

## Interface
Parameters:
- `SYNC_BYTE`, 8'h80: expected first byte of every packet.
- `MAX_BYTES`, 64: maximum bytes stored per packet (PID included); must be ≤ 2^`CNT_W` − 1.
- `CNT_W`, 7: width of `byte_count`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `d_edge`  in  1  one-cycle pulse; a line transition was detected.
- `eop`  in  1  level; SE0 is present on the line. Valid only when qualified by `shift_enable`.
- `shift_enable`  in  1  one-cycle bit-sample strobe from the timer.
- `byte_received`  in  1  one-cycle pulse; 8 bits have been shifted.
- `rcv_data`  in  8  shift register contents; valid with `byte_received` and stable for the following cycle.
- `fifo_full`  in  1  RX FIFO cannot accept a write.
- `rcving`  out  1  packet in progress; enables and holds the timer.
- `w_enable`  out  1  one-cycle FIFO write strobe; data is `rcv_data`.
- `r_error`  out  1  sticky error for the current or last packet.
- `pkt_done`  out  1  one-cycle pulse on an error-free EOP.
- `byte_count`  out  `CNT_W`  bytes written in the current packet.

## Operation
- States: IDLE, SYNC_WAIT, DATA_WAIT, STORE, ERR_WAIT, EOP_END.
- IDLE:
  - `rcving`=0.
  - On `d_edge`: go to SYNC_WAIT, clear `r_error`, clear `byte_count`.
- SYNC_WAIT:
  - On `byte_received`: go to DATA_WAIT if `rcv_data`==`SYNC_BYTE`; otherwise set `r_error` and go to ERR_WAIT.
  - On `shift_enable`&&`eop`: set `r_error` and go to EOP_END.
- DATA_WAIT:
  - On `byte_received`: go to STORE.
  - On `shift_enable`&&`eop`: go to EOP_END. Pulse `pkt_done` on this transition if `r_error`=0 and `byte_count`≥1.
  - If `byte_count`=0 at EOP, set `r_error` instead (empty packet).
- STORE (exactly one cycle). Reject the byte if either of these holds:
  - `fifo_full`=1.
  - `byte_count`==`MAX_BYTES`.
- STORE outcome:
  - On reject: no write, set `r_error`, go to ERR_WAIT.
  - Otherwise: `w_enable`=1, `byte_count`+1, go to DATA_WAIT.
- ERR_WAIT: ignore bytes. On `shift_enable`&&`eop`, go to EOP_END.
- EOP_END: on `d_edge` (SE0→J), go to IDLE. `r_error` keeps its value until the next packet start.
- `rcving`=1 in every state except IDLE.
- Priority when `byte_received` and `shift_enable`&&`eop` occur in the same cycle: EOP wins and the byte is discarded.
- `d_edge` is ignored outside IDLE and EOP_END.
- `byte_count` saturates at `MAX_BYTES` and never wraps.

## Timing
- Reset values: state=IDLE, `rcving`=0, `w_enable`=0, `r_error`=0, `pkt_done`=0, `byte_count`=0.
- `rst` asserted mid-packet returns the block to IDLE on the next edge. No write, and no `pkt_done`, occurs in that cycle.
- `d_edge` in cycle N → `rcving`=1 from cycle N+1.
- `byte_received` in cycle N → STORE in cycle N+1. `w_enable` is high during N+1 only, and `byte_count` shows the increment in N+2.
- `pkt_done`, `r_error` set, and all state changes take effect on the edge after the qualifying input.
- `w_enable` and `pkt_done` are never high in the same cycle.

## Configuration
- `USB_RX_PID_CHECK_EN` defined:
  - In STORE with `byte_count`==0, the byte is also rejected if `rcv_data[3:0]` != ~`rcv_data[7:4]`.
  - A rejected PID sets `r_error`, is not written, and sends the FSM to ERR_WAIT.
- `USB_RX_PID_CHECK_EN` undefined: the first byte is stored without checking.

## Structure
- Package `usb_rx_pkg` holds:
  - the state enum type `rx_state_t`;
  - the default SYNC constant `USB_SYNC_BYTE` = 8'h80.
- Sub-module `usb_pid_check`: a combinational PID complement checker, instantiated only under `USB_RX_PID_CHECK_EN`.
- All remaining logic lives in a single FSM plus the `byte_count` and `r_error` registers.

## Test plan
- Good packet:
  - Stimulus: `d_edge`, then bytes 8'h80, 8'hC3, 8'h11, 8'h22, then EOP, then `d_edge`.
  - Expected: 3 `w_enable` pulses with those 3 data bytes, `byte_count`=3, one `pkt_done`, `r_error`=0, `rcving` back to 0.
- Bad SYNC:
  - Stimulus: first byte 8'h81, then 2 bytes, then EOP.
  - Expected: no `w_enable`, `r_error`=1, no `pkt_done`.
  - Follow-up: the next packet's `d_edge` clears `r_error`.
- FIFO full:
  - Stimulus: `fifo_full`=1 during the second data byte.
  - Expected: exactly 1 write, `r_error`=1, later bytes ignored until EOP.
- Overflow:
  - Stimulus: `MAX_BYTES`=4, send SYNC plus 5 bytes.
  - Expected: 4 writes, then `r_error`=1, and `byte_count` holds at 4.
- Simultaneous events:
  - Stimulus: `byte_received` in the same cycle as `shift_enable`&&`eop`.
  - Expected: no write and direct entry to EOP_END.
- Reset mid-packet:
  - Stimulus: `rst` during DATA_WAIT after 2 bytes.
  - Expected: all outputs 0 next cycle.
- With `USB_RX_PID_CHECK_EN`:
  - Stimulus: PID byte 8'hC4.
  - Expected: `r_error`=1 and no write.
